// File: rtl/mul_arbiter.sv
// Two-requester shift-add multiplier with a round-robin front end.
// A request accepted in IDLE latches its operands as magnitudes plus a
// result sign, then MUL runs a fixed WIDTH iterations, one per clock.
// One further MUL cycle registers the signed result and the overflow
// flag, and DONE then pulses oDone for a single cycle.
// oState exposes the FSM state for debug.
//
// Handshake: oAckN is a one-cycle pulse in the cycle after the accepting
// edge. iReqN is sampled only in IDLE. A request that is held high while
// the block is busy is simply seen again at the next IDLE edge, because
// nothing is queued. oDone is a one-cycle pulse, and oResult, oOverflow
// and oOwner hold their values until the next oDone.
module mul_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iReq0,
  input  logic             iReq1,
  input  logic             iSigned0,
  input  logic             iSigned1,
  input  logic [WIDTH-1:0] iDataA0,
  input  logic [WIDTH-1:0] iDataB0,
  input  logic [WIDTH-1:0] iDataA1,
  input  logic [WIDTH-1:0] iDataB1,
  output logic             oAck0,
  output logic             oAck1,
  output logic             oBusy,
  output logic             oDone,
  output logic             oOwner,
  output logic [WIDTH-1:0] oResult,
  output logic             oOverflow,
  output logic [1:0]       oState
);

  localparam int CW = $clog2(WIDTH + 1);
  // Largest positive magnitude, and largest negative magnitude.
  localparam logic [2*WIDTH-1:0] MAX_POS = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] MAX_NEG = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  state_t             state;
  state_t             stateNext;
  logic               pointer;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               sign;
  logic               opSigned;
  logic               curOwner;

  logic               anyReq;
  logic               winner;
  logic               selSigned;
  logic [WIDTH-1:0]   selA;
  logic [WIDTH-1:0]   selB;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic               lastIter;
  logic               ovf;
  logic [WIDTH-1:0]   resVal;

  // Arbitration and operand selection: the pointer breaks ties, and a lone requester always wins.
  always_comb begin
    anyReq    = iReq0 | iReq1;
    winner    = (iReq0 && iReq1) ? pointer : iReq1;
    selSigned = winner ? iSigned1 : iSigned0;
    selA      = winner ? iDataA1 : iDataA0;
    selB      = winner ? iDataB1 : iDataB0;
    magA      = (selSigned && selA[WIDTH-1]) ? (~selA + 1'b1) : selA;
    magB      = (selSigned && selB[WIDTH-1]) ? (~selB + 1'b1) : selB;
  end

  // Final result and overflow, taken from the accumulated magnitude.
  always_comb begin
    lastIter = (count == CW'(WIDTH));
    resVal   = sign ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    if (!opSigned)
      ovf = |acc[2*WIDTH-1:WIDTH];
    else if (sign)
      ovf = acc > MAX_NEG;
    else
      ovf = acc > MAX_POS;
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic.
  always_comb begin
    stateNext = IDLE;
    case (state)
      IDLE:    stateNext = anyReq ? MUL : IDLE;
      MUL:     stateNext = lastIter ? DONE : MUL;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    oBusy  = (state != IDLE);
    oDone  = (state == DONE);
    oState = state;
  end

  // Datapath: latch at acceptance, iterate in MUL, register the result on the final MUL edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pointer   <= 1'b0;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      sign      <= 1'b0;
      opSigned  <= 1'b0;
      curOwner  <= 1'b0;
      oAck0     <= 1'b0;
      oAck1     <= 1'b0;
      oOwner    <= 1'b0;
      oResult   <= '0;
      oOverflow <= 1'b0;
    end else begin
      oAck0 <= 1'b0;
      oAck1 <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            oAck0    <= ~winner;
            oAck1    <= winner;
            pointer  <= ~winner;
            curOwner <= winner;
            opSigned <= selSigned;
            sign     <= selSigned & (selA[WIDTH-1] ^ selB[WIDTH-1]);
            mcand    <= {{WIDTH{1'b0}}, magA};
            mplier   <= magB;
            acc      <= '0;
            count    <= '0;
          end
        end
        MUL: begin
          if (!lastIter) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
          end else begin
            oResult   <= resVal;
            oOverflow <= ovf;
            oOwner    <= curOwner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
